sle_pipe: RTL and testbench
===========================

# sle_pipe

Parametrised elastic register pipeline built from SLE-style storage stages. Each of DEPTH stages holds a WIDTH-bit word plus a valid bit. The pipeline keeps the cell semantics of the single-bit flip-flop primitive: asynchronous load from ADn, synchronous load from SD under SLn, and a global clock enable EN. On top of those it adds a valid/ready handshake, bubble collapsing and an occupancy count. It sits between fabric datapaths as a retiming/buffer stage and replaces hand-chained single-bit cell instances.

## Interface
- WIDTH, 8, data width per stage (>=1)
- DEPTH, 3, number of stages (>=1)
- OW, $clog2(DEPTH+1), occupancy width (derived, not overridden)

- CLK  input  1  clock, all state on rising edge
- ALn  input  1  asynchronous active-low reset / async load; one clock only
- ADn  input  WIDTH  async load value, inverted: while ALn=0 every stage data <= ~ADn
- D  input  WIDTH  write data
- D_VALID  input  1  write request
- D_READY  output  1  write accepted when D_VALID & D_READY at edge
- SD  input  WIDTH  synchronous load value
- SLn  input  1  active-low synchronous load/flush
- EN  input  1  global clock enable; 0 freezes all state
- Q  output  WIDTH  data of stage DEPTH-1
- Q_VALID  output  1  stage DEPTH-1 holds a valid word
- Q_READY  input  1  sink accepts Q when Q_VALID & Q_READY at edge
- OCC  output  OW  count of valid stages, 0..DEPTH

## Operation
- Priority: ALn (async) > EN=0 (hold) > SLn=0 (sync load) > normal flow.
- ALn=0: immediately and while held, all stage data = ~ADn, all valid = 0; Q=~ADn, Q_VALID=0, OCC=0, D_READY=0.
- EN=0 at edge: no state change; D_READY=0; transfers not counted even if Q_VALID&Q_READY.
- SLn=0 & EN=1 at edge: every stage data <= SD, every valid <= 0 (flush); D_READY=0 that cycle; no word accepted; no word delivered.
- Normal flow (EN=1, SLn=1):
  - drain: last stage empties when Q_VALID & Q_READY.
  - stage k (k<DEPTH-1) advances its word into k+1 when k valid and (k+1 empty or k+1 advancing).
  - stage 0 loads D when D_VALID & D_READY.
  - D_READY = EN & SLn & ALn & (stage0 empty or stage0 advancing); combinational through the stage chain (full pass-through when Q_READY=1).
  - bubbles collapse: an empty stage always accepts from its predecessor.
- Empty stages keep their previous data (no update on non-transfer); Q shows last held value when Q_VALID=0.
- OCC = popcount(valid), combinational from registered valid bits.
- Words leave in acceptance order; no drop, no duplication.

## Timing
- Reset values: Q=~ADn, Q_VALID=0, OCC=0, D_READY=0.
- D_READY rises combinationally once ALn=1, EN=1, SLn=1; first accept possible at first rising edge after ALn deasserts, if ALn deasserts before that edge's setup time.
- Latency: word accepted at edge n is in stage 0 after n. With no stall it shows on Q with Q_VALID=1 after edge n+DEPTH-1 (DEPTH=1: right after edge n).
- Throughput: 1 word/cycle sustained with Q_READY=1.
- Full (OCC=DEPTH) and Q_READY=0: D_READY=0. Full and Q_READY=1: D_READY=1; drain and accept happen on the same edge, and OCC stays DEPTH.
- Simultaneous SLn=0 with D_VALID/Q_READY: flush wins; neither transfer occurs.
- ALn asserted mid-stream: in-flight words are discarded immediately; no partial state survives.

## Test plan
- Reset: WIDTH=8, ADn=8'h5A, ALn=0 -> Q=8'hA5, Q_VALID=0, OCC=0, D_READY=0. Release ALn -> D_READY=1 with EN=1, SLn=1.
- Streaming: DEPTH=3, Q_READY=1, D=1,2,3,4 on consecutive edges -> Q_VALID first high after edge 3 with Q=1, then 2,3,4 on following cycles; OCC steady at 3.
- Backpressure: Q_READY=0, push 5 words -> 3 accepted, D_READY=0, OCC=3. Raise Q_READY -> words 1,2,3 in order, then 4,5 once offered again.
- Bubble collapse: push word 7, idle 2 cycles, Q_READY=0 -> word 7 at stage 2 after 2 more edges. Push 8 -> OCC=2, next accept allowed.
- Sync load: OCC=2, SLn=0, SD=8'h3C, D_VALID=1 -> after edge Q=8'h3C, Q_VALID=0, OCC=0, D not accepted.
- Enable/async: EN=0 with D_VALID=Q_READY=1 for 4 edges -> no change to Q/OCC. Assert ALn mid-stream with ADn=8'hFF -> Q=8'h00, OCC=0 without a clock edge.

Source files
------------

// File: rtl/sle_pipe.sv
// Elastic register pipeline of SLE-style storage stages: async load from ADn,
// sync load/flush from SD, global enable, valid/ready flow with bubble collapsing.
module sle_stage #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ALn,
  input  logic [WIDTH-1:0] ADn,
  input  logic             EN,
  input  logic             SLn,
  input  logic [WIDTH-1:0] SD,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             unld,
  output logic [WIDTH-1:0] q,
  output logic             vld
);
  always_ff @(posedge CLK or negedge ALn) begin
    if (!ALn) begin
      q   <= ~ADn;
      vld <= 1'b0;
    end else if (EN) begin
      if (!SLn) begin
        q   <= SD;
        vld <= 1'b0;
      end else if (ld) begin
        q   <= din;
        vld <= 1'b1;
      end else if (unld) begin
        vld <= 1'b0;
      end
    end
  end
endmodule

module sle_pipe #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 3,
  localparam int OW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             ALn,
  input  logic [WIDTH-1:0] ADn,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  output logic             D_READY,
  input  logic [WIDTH-1:0] SD,
  input  logic             SLn,
  input  logic             EN,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  input  logic             Q_READY,
  output logic [OW-1:0]    OCC
);
  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0]            out_go;
  logic [DEPTH-1:0]            free;
  logic [DEPTH-1:0]            ld;
  logic                        go;

  assign go = EN & SLn & ALn;

  // Ready ripples back from the sink: a stage is free if empty or moving on this edge.
  always_comb begin
    out_go = '0;
    free   = '0;
    out_go[DEPTH-1] = go & valid[DEPTH-1] & Q_READY;
    free[DEPTH-1]   = ~valid[DEPTH-1] | out_go[DEPTH-1];
    for (int k = DEPTH - 2; k >= 0; k--) begin
      out_go[k] = go & valid[k] & free[k+1];
      free[k]   = ~valid[k] | out_go[k];
    end
  end

  assign D_READY = go & free[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stg
    logic [WIDTH-1:0] din;
    if (k == 0) begin : g_head
      assign ld[k] = D_VALID & D_READY;
      assign din   = D;
    end else begin : g_body
      assign ld[k] = out_go[k-1];
      assign din   = data[k-1];
    end
    sle_stage #(.WIDTH(WIDTH)) u_stg (
      .CLK  (CLK),
      .ALn  (ALn),
      .ADn  (ADn),
      .EN   (EN),
      .SLn  (SLn),
      .SD   (SD),
      .ld   (ld[k]),
      .din  (din),
      .unld (out_go[k]),
      .q    (data[k]),
      .vld  (valid[k])
    );
  end

  // Q tracks ~ADn continuously while async load is held, not just at its edge.
  assign Q       = ALn ? data[DEPTH-1] : ~ADn;
  assign Q_VALID = valid[DEPTH-1];

  always_comb begin
    OCC = '0;
    for (int k = 0; k < DEPTH; k++) OCC = OCC + OW'(valid[k]);
  end
endmodule

// File: tb/tb_sle_pipe.sv
// Directed bench for sle_pipe (WIDTH=8, DEPTH=3) with queue scoreboard and output monitor.
module tb_sle_pipe;
  logic       CLK = 1'b0;
  logic       ALn, D_VALID, D_READY, SLn, EN, Q_VALID, Q_READY;
  logic [7:0] ADn, D, SD, Q;
  logic [1:0] OCC;

  logic [7:0] sb[$];
  int n_vec = 0;
  int n_err = 0;

  sle_pipe #(.WIDTH(8), .DEPTH(3)) dut (
    .CLK(CLK), .ALn(ALn), .ADn(ADn), .D(D), .D_VALID(D_VALID), .D_READY(D_READY),
    .SD(SD), .SLn(SLn), .EN(EN), .Q(Q), .Q_VALID(Q_VALID), .Q_READY(Q_READY), .OCC(OCC)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Delivery monitor: a transfer happens on the coming edge when the handshake is live.
  always @(negedge CLK) begin
    if (ALn && EN && SLn && Q_VALID && Q_READY) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got %0h expected none", Q);
      end else begin
        chk("q_word", 32'(Q), 32'(sb.pop_front()));
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    if (D_VALID && D_READY) sb.push_back(D);
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    bit done = 0;
    D = w;
    D_VALID = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge CLK);
      if (D_READY) begin
        sb.push_back(w);
        done = 1;
      end
      @(posedge CLK);
      #1;
    end
    D_VALID = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: got no accept expected accept of %0h", w);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ALn = 1'b0; ADn = 8'h5A; EN = 1'b1; SLn = 1'b1;
    D_VALID = 1'b0; Q_READY = 1'b0; D = '0; SD = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_q", 32'(Q), 32'hA5);
    chk("rst_qv", 32'(Q_VALID), 0);
    chk("rst_occ", 32'(OCC), 0);
    chk("rst_drdy", 32'(D_READY), 0);
    ALn = 1'b1;
    #1;
    chk("rel_drdy", 32'(D_READY), 1);

    // streaming
    Q_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      D = 8'(i);
      D_VALID = 1'b1;
      step();
      if (i == 3) begin
        chk("strm_first_qv", 32'(Q_VALID), 1);
        chk("strm_first_q", 32'(Q), 1);
      end
      if (i >= 3) chk("strm_occ", 32'(OCC), 3);
    end
    D_VALID = 1'b0;
    repeat (3) step();
    chk("strm_drained_occ", 32'(OCC), 0);
    chk("strm_sb_empty", 32'(sb.size()), 0);

    // backpressure
    Q_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      D = 8'(11 + i);
      D_VALID = 1'b1;
      step();
    end
    #1;
    chk("bp_drdy", 32'(D_READY), 0);
    chk("bp_occ", 32'(OCC), 3);
    chk("bp_q", 32'(Q), 11);
    D_VALID = 1'b0;
    Q_READY = 1'b1;
    repeat (3) step();
    push_word(8'd14);
    push_word(8'd15);
    repeat (3) step();
    chk("bp_sb_empty", 32'(sb.size()), 0);
    chk("bp_occ_end", 32'(OCC), 0);

    // bubble collapse
    Q_READY = 1'b0;
    push_word(8'd7);
    repeat (2) step();
    chk("bub_q", 32'(Q), 7);
    chk("bub_qv", 32'(Q_VALID), 1);
    chk("bub_occ1", 32'(OCC), 1);
    push_word(8'd8);
    chk("bub_occ2", 32'(OCC), 2);
    chk("bub_drdy", 32'(D_READY), 1);

    // sync load / flush
    SLn = 1'b0; SD = 8'h3C; D = 8'h99; D_VALID = 1'b1;
    #1;
    chk("sl_drdy", 32'(D_READY), 0);
    step();
    sb.delete();
    chk("sl_q", 32'(Q), 32'h3C);
    chk("sl_qv", 32'(Q_VALID), 0);
    chk("sl_occ", 32'(OCC), 0);
    SLn = 1'b1;
    D_VALID = 1'b0;

    // enable hold, then full pass-through
    push_word(8'd21);
    push_word(8'd22);
    push_word(8'd23);
    chk("en_full_occ", 32'(OCC), 3);
    chk("en_full_q", 32'(Q), 21);
    EN = 1'b0; Q_READY = 1'b1; D = 8'h77; D_VALID = 1'b1;
    #1;
    chk("en_drdy", 32'(D_READY), 0);
    repeat (4) step();
    chk("en_hold_q", 32'(Q), 21);
    chk("en_hold_occ", 32'(OCC), 3);
    EN = 1'b1; D = 8'd24;
    #1;
    chk("full_pass_drdy", 32'(D_READY), 1);
    step();
    chk("full_pass_occ", 32'(OCC), 3);
    D_VALID = 1'b0;
    step();

    // async load mid-stream
    ADn = 8'hFF;
    ALn = 1'b0;
    #2;
    chk("al_q", 32'(Q), 32'h00);
    chk("al_qv", 32'(Q_VALID), 0);
    chk("al_occ", 32'(OCC), 0);
    chk("al_drdy", 32'(D_READY), 0);
    sb.delete();
    @(posedge CLK);
    #1;
    ALn = 1'b1;
    ADn = 8'h00;
    #1;
    chk("al_rel_drdy", 32'(D_READY), 1);
    push_word(8'h42);
    repeat (3) step();
    chk("final_sb_empty", 32'(sb.size()), 0);
    chk("final_occ", 32'(OCC), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
